wor_bus_arbiter: RTL and testbench

- Upstream stage for a consumer that reads a wired-OR (wor) resolved bus.
- Arbitrates N requesters round-robin and gates the granted requester's data onto an internal wor bus; all other drivers present zero.
- Registers the resolved value into an output slot with a valid/ready handshake and tags it with the source index.
- Counts completed transfers; flags any cycle where more than one driver reaches the wor bus (must never happen).

---
 rtl/wor_bus_pkg.sv | 28 ++
 rtl/wor_rr_pick.sv | 31 +++
 rtl/wor_bus_arbiter.sv | 82 ++++++++
 tb/tb_wor_bus_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wor_bus_pkg.sv
// Shared defaults and the round-robin pick function for the wired-OR bus arbiter.
package wor_bus_pkg;

    localparam int N_DEF  = 4;
    localparam int W_DEF  = 8;
    localparam int CW_DEF = 16;
    localparam int SW_DEF = $clog2(N_DEF);
    localparam int N_MAX  = 16;

    typedef logic [SW_DEF-1:0] src_t;

    // One-hot of the first set bit of req[n-1:0] at or above ptr, wrapping n-1 -> 0.
    // Scanning from the far end down lets the nearest candidate overwrite the rest.
    function automatic logic [N_MAX-1:0] rr_next(input logic [N_MAX-1:0] req,
                                                 input int ptr,
                                                 input int n);
        logic [N_MAX-1:0] g;
        int               idx;
        g = '0;
        for (int k = N_MAX - 1; k >= 0; k--) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && req[idx[3:0]]) g = N_MAX'(1) << idx[3:0];
        end
        return g;
    endfunction

endpackage

// File: rtl/wor_rr_pick.sv
// Combinational round-robin selector: one-hot grant, its index, and an any-grant flag.
module wor_rr_pick
    import wor_bus_pkg::*;
#(
    parameter  int N  = N_DEF,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [N_MAX-1:0] req_ext;
    logic [N_MAX-1:0] pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = rr_next(req_ext, 32'(ptr), N);
        gnt            = en ? pick[N-1:0] : '0;
        any            = |gnt;
        idx            = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) idx = SW'(i);
        end
    end

endmodule

// File: rtl/wor_bus_arbiter.sv
// Round-robin arbiter feeding a wired-OR bus into a registered valid/ready output slot,
// with a saturating transfer counter and a sticky multi-driver flag.
module wor_bus_arbiter
    import wor_bus_pkg::*;
#(
    parameter  int N  = N_DEF,
    parameter  int W  = W_DEF,
    parameter  int CW = CW_DEF,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N*W-1:0] data,
    output logic [N-1:0]  gnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_src,
    output logic [CW-1:0] xfer_count,
    output logic          collision
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] pick_idx;
    logic          pick_any;
    logic          slot_free;
    logic [4:0]    drv_cnt;
    wor   [W-1:0]  bus;

    assign slot_free = !out_valid || out_ready;

    // Holding the enable low during reset keeps every driver off the bus.
    wor_rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (ptr),
        .en  (slot_free && !rst),
        .gnt (gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign bus = data[i*W +: W] & {W{gnt[i]}};
    end

    always_comb begin
        drv_cnt = '0;
        for (int i = 0; i < N; i++) begin
            drv_cnt = drv_cnt + 5'(gnt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            ptr        <= '0;
            xfer_count <= '0;
            collision  <= 1'b0;
        end else begin
            if (pick_any) begin
                out_data  <= bus;
                out_src   <= pick_idx;
                out_valid <= 1'b1;
                ptr       <= (pick_idx == SW'(N - 1)) ? '0 : pick_idx + SW'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready && xfer_count != '1) begin
                xfer_count <= xfer_count + CW'(1);
            end

            if (drv_cnt > 5'd1) begin
                collision <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wor_bus_arbiter.sv
// Self-checking bench for wor_bus_arbiter: a reference model predicts grants and
// queues expected output words, popped as the consumer accepts them.
module tb_wor_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] data;
    logic [N-1:0]  gnt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    out_src;
    logic [CW-1:0] xfer_count;
    logic          collision;

    wor_bus_arbiter #(.N(N), .W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .gnt        (gnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .xfer_count (xfer_count),
        .collision  (collision)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   s;
    } exp_t;

    exp_t          exp_q[$];
    int            m_ptr;
    bit            m_valid;
    logic [CW-1:0] m_count;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            g;
    logic [N-1:0]  eg;

    function automatic int model_pick(input logic [N-1:0] r, input int p, input bit free);
        if (!free) return -1;
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input bit rdy);
        int  pg;
        bit  acc;
        pg  = model_pick(r, m_ptr, !m_valid || rdy);
        acc = m_valid && rdy;
        if (acc) begin
            void'(exp_q.pop_front());
            if (m_count != '1) m_count = m_count + 1'b1;
        end
        if (pg >= 0) begin
            exp_q.push_back('{d: data[pg*W +: W], s: 2'(pg)});
            m_valid = 1'b1;
            m_ptr   = (pg + 1) % N;
        end else if (acc) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_clear();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_count = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1; data = '1;
        #1;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt_in_rst got %b want 0000", gnt); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0; req = '0;
        model_clear();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt c%0d got %b want 0000", c, gnt); else n_pass++;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_idle_valid c%0d got %b want 0", c, out_valid); else n_pass++;
            n_checks++; if (xfer_count !== '0) $display("FAIL reset_count c%0d got %0d want 0", c, xfer_count); else n_pass++;
            n_checks++; if (collision !== 1'b0) $display("FAIL reset_collision c%0d got %b want 0", c, collision); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] seq [3] = '{4'b0100, 4'b0000, 4'b0000};
        data = '0;
        data[2*W +: W] = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            req = seq[c]; out_ready = 1'b1; #1;
            g  = model_pick(req, m_ptr, !m_valid || out_ready);
            eg = (g >= 0) ? N'(1 << g) : '0;
            n_checks++; if (gnt !== eg) $display("FAIL single_gnt c%0d got %b want %b", c, gnt, eg); else n_pass++;
            n_checks++; if (out_valid !== m_valid) $display("FAIL single_valid c%0d got %b want %b", c, out_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++;
                if ({out_data, out_src} !== {exp_q[0].d, exp_q[0].s})
                    $display("FAIL single_word c%0d got %h/%0d want %h/%0d", c, out_data, out_src, exp_q[0].d, exp_q[0].s);
                else n_pass++;
            end
            n_checks++; if (xfer_count !== m_count) $display("FAIL single_count c%0d got %0d want %0d", c, xfer_count, m_count); else n_pass++;
            model_step(req, out_ready);
            @(negedge clk);
        end
        #1;
        n_checks++; if (xfer_count !== 16'd1) $display("FAIL single_final_count got %0d want 1", xfer_count); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] src_seq[$];
        int         exp_order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) data[i*W +: W] = 8'h10 + 8'(i);
        for (int c = 0; c < 7; c++) begin
            req = (c < 5) ? 4'b1111 : 4'b0000; out_ready = 1'b1; #1;
            g  = model_pick(req, m_ptr, !m_valid || out_ready);
            eg = (g >= 0) ? N'(1 << g) : '0;
            n_checks++; if (gnt !== eg) $display("FAIL rr_gnt c%0d got %b want %b", c, gnt, eg); else n_pass++;
            n_checks++; if (out_valid !== m_valid) $display("FAIL rr_valid c%0d got %b want %b", c, out_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++;
                if ({out_data, out_src} !== {exp_q[0].d, exp_q[0].s})
                    $display("FAIL rr_word c%0d got %h/%0d want %h/%0d", c, out_data, out_src, exp_q[0].d, exp_q[0].s);
                else n_pass++;
            end
            if (out_valid && out_ready) src_seq.push_back(out_src);
            model_step(req, out_ready);
            @(negedge clk);
        end
        n_checks++; if (src_seq.size() != 5) $display("FAIL rr_words got %0d want 5", src_seq.size()); else n_pass++;
        for (int i = 0; i < 5 && i < src_seq.size(); i++) begin
            n_checks++;
            if (int'(src_seq[i]) != exp_order[i]) $display("FAIL rr_order[%0d] got %0d want %0d", i, src_seq[i], exp_order[i]);
            else n_pass++;
        end
        #1;
        n_checks++; if (xfer_count !== 16'd5) $display("FAIL rr_count got %0d want 5", xfer_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] seq [8] = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        bit           rdy [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        do_reset();
        data = '0;
        data[0 +: W] = 8'h3C;
        data[W +: W] = 8'hC3;
        for (int c = 0; c < 8; c++) begin
            req = seq[c]; out_ready = rdy[c]; #1;
            g  = model_pick(req, m_ptr, !m_valid || out_ready);
            eg = (g >= 0) ? N'(1 << g) : '0;
            n_checks++; if (gnt !== eg) $display("FAIL bp_gnt c%0d got %b want %b", c, gnt, eg); else n_pass++;
            n_checks++; if (out_valid !== m_valid) $display("FAIL bp_valid c%0d got %b want %b", c, out_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++;
                if ({out_data, out_src} !== {exp_q[0].d, exp_q[0].s})
                    $display("FAIL bp_word c%0d got %h/%0d want %h/%0d", c, out_data, out_src, exp_q[0].d, exp_q[0].s);
                else n_pass++;
            end
            n_checks++; if (xfer_count !== m_count) $display("FAIL bp_count c%0d got %0d want %0d", c, xfer_count, m_count); else n_pass++;
            if (c >= 1 && c <= 4) begin
                n_checks++; if (out_data !== 8'h3C) $display("FAIL bp_hold c%0d got %h want 3c", c, out_data); else n_pass++;
            end
            if (c == 5) begin
                n_checks++; if (gnt !== 4'b0010) $display("FAIL bp_release_gnt got %b want 0010", gnt); else n_pass++;
            end
            model_step(req, out_ready);
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] seq [5] = '{4'b0100, 4'b1001, 4'b0001, 4'b0000, 4'b0000};
        logic [1:0]   src_seq[$];
        int           exp_src [3] = '{2, 3, 0};
        do_reset();
        data = '0;
        data[0 +: W]   = 8'h5A;
        data[2*W +: W] = 8'h77;
        data[3*W +: W] = 8'hE1;
        for (int c = 0; c < 5; c++) begin
            req = seq[c]; out_ready = 1'b1; #1;
            g  = model_pick(req, m_ptr, !m_valid || out_ready);
            eg = (g >= 0) ? N'(1 << g) : '0;
            n_checks++; if (gnt !== eg) $display("FAIL wrap_gnt c%0d got %b want %b", c, gnt, eg); else n_pass++;
            n_checks++; if (out_valid !== m_valid) $display("FAIL wrap_valid c%0d got %b want %b", c, out_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++;
                if ({out_data, out_src} !== {exp_q[0].d, exp_q[0].s})
                    $display("FAIL wrap_word c%0d got %h/%0d want %h/%0d", c, out_data, out_src, exp_q[0].d, exp_q[0].s);
                else n_pass++;
            end
            if (out_valid && out_ready) src_seq.push_back(out_src);
            model_step(req, out_ready);
            @(negedge clk);
        end
        n_checks++; if (src_seq.size() != 3) $display("FAIL wrap_words got %0d want 3", src_seq.size()); else n_pass++;
        for (int i = 0; i < 3 && i < src_seq.size(); i++) begin
            n_checks++;
            if (int'(src_seq[i]) != exp_src[i]) $display("FAIL wrap_src[%0d] got %0d want %0d", i, src_seq[i], exp_src[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] seq [3] = '{4'b1010, 4'b0000, 4'b0000};
        do_reset();
        data = '0;
        data[W +: W]   = 8'h42;
        data[2*W +: W] = 8'h99;
        data[3*W +: W] = 8'hF0;
        req = 4'b0100; out_ready = 1'b0; #1;
        n_checks++; if (gnt !== 4'b0100) $display("FAIL mr_first_gnt got %b want 0100", gnt); else n_pass++;
        model_step(req, out_ready);
        @(negedge clk);
        req = 4'b0000; #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mr_held_valid got %b want 1", out_valid); else n_pass++;
        #2;
        rst = 1'b1; req = 4'b1010;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mr_async_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL mr_gnt_in_rst got %b want 0000", gnt); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            req = seq[c]; out_ready = 1'b1; #1;
            g  = model_pick(req, m_ptr, !m_valid || out_ready);
            eg = (g >= 0) ? N'(1 << g) : '0;
            n_checks++; if (gnt !== eg) $display("FAIL mr_gnt c%0d got %b want %b", c, gnt, eg); else n_pass++;
            n_checks++; if (out_valid !== m_valid) $display("FAIL mr_valid c%0d got %b want %b", c, out_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++;
                if ({out_data, out_src} !== {exp_q[0].d, exp_q[0].s})
                    $display("FAIL mr_word c%0d got %h/%0d want %h/%0d", c, out_data, out_src, exp_q[0].d, exp_q[0].s);
                else n_pass++;
            end
            if (c == 0) begin
                n_checks++; if (gnt !== 4'b0010) $display("FAIL mr_post_gnt got %b want 0010", gnt); else n_pass++;
            end
            model_step(req, out_ready);
            @(negedge clk);
        end
        #1;
        n_checks++; if (xfer_count !== 16'd1) $display("FAIL mr_count got %0d want 1", xfer_count); else n_pass++;
        n_checks++; if (collision !== 1'b0) $display("FAIL mr_collision got %b want 0", collision); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; data = '0; out_ready = 1'b1;
        model_clear();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
